decode_stage_nway: RTL

//  Parametrised N-lane decode stage that generalises the dual-issue decode: LANES instruction slots, each with
//  an XLEN-wide datapath. Per lane: multi-port register file read with W->D bypass, MEM-stage forwarding select,

---
 rtl/decode_pkg.sv | 34 +++
 rtl/regfile_mp.sv | 53 +++++
 rtl/decode_stage_nway.sv | 115 +++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants, instruction view and lane-slice helpers for the N-lane decode stage
package decode_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN     = 32;
  localparam int RW       = 5;

  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_XORI = 6'h0E;

  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  // rd occupies imm[15:11]; both views of the low half-word are decoded in parallel
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } itype_t;

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int rport_lo(input int lanes, input int lane, input logic is_rt);
    return (is_rt ? lanes + lane : lane) * RW;
  endfunction

  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OPC_ANDI) || (op == OPC_ORI) || (op == OPC_XORI);
  endfunction

endpackage

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file, 2*LANES reads, LANES writes, write-before-read bypass
module regfile_mp
  import decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES-1:0]          we,
  input  logic [LANES*RW-1:0]       wa,
  input  logic [LANES*XLEN-1:0]     wd,
  input  logic [2*LANES*RW-1:0]     ra,
  output logic [2*LANES*XLEN-1:0]   rd
);

  logic [XLEN-1:0] regs [NREGS];

  // ascending lane order: the highest writing lane's assignment is the one that sticks
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (we[l] && wa[lane_lo(l, RW) +: RW] != REG_ZERO &&
            int'(wa[lane_lo(l, RW) +: RW]) < NREGS)
          regs[wa[lane_lo(l, RW) +: RW]] <= wd[lane_lo(l, XLEN) +: XLEN];
      end
    end
  end

  for (genvar p = 0; p < 2*LANES; p++) begin : g_rport
    logic [RW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = ra[lane_lo(p, RW) +: RW];

    always_comb begin
      val = '0;
      if (addr != REG_ZERO && int'(addr) < NREGS) begin
        val = regs[addr];
        for (int l = 0; l < LANES; l++) begin
          if (we[l] && wa[lane_lo(l, RW) +: RW] == addr)
            val = wd[lane_lo(l, XLEN) +: XLEN];
        end
      end
    end

    assign rd[lane_lo(p, XLEN) +: XLEN] = val;
  end

endmodule

// File: rtl/decode_stage_nway.sv
// rtl/decode_stage_nway.sv - LANES-wide decode: operand read/forward, branch/jump targets, ID/EX register
module decode_stage_nway
  import decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  localparam int FW   = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_d,
  input  logic                    flush_e,
  input  logic [LANES-1:0]        valid_d,
  input  logic [LANES*ILEN-1:0]   instr_d,
  input  logic [LANES*XLEN-1:0]   pcplus4_d,
  input  logic [LANES*FW-1:0]     fwd_a_d,
  input  logic [LANES*FW-1:0]     fwd_b_d,
  input  logic [LANES*XLEN-1:0]   aluout_m,
  input  logic [LANES-1:0]        regwrite_w,
  input  logic [LANES*RW-1:0]     writereg_w,
  input  logic [LANES*XLEN-1:0]   result_w,
  output logic [LANES-1:0]        equal_d,
  output logic [LANES*XLEN-1:0]   pcbranch_d,
  output logic [LANES*XLEN-1:0]   jtarget_d,
  output logic [LANES-1:0]        valid_e,
  output logic [LANES*XLEN-1:0]   rd1_e,
  output logic [LANES*XLEN-1:0]   rd2_e,
  output logic [LANES*XLEN-1:0]   imm_e,
  output logic [LANES*RW-1:0]     rs_e,
  output logic [LANES*RW-1:0]     rt_e,
  output logic [LANES*RW-1:0]     rd_e
);

  logic [2*LANES*RW-1:0]   rf_ra;
  logic [2*LANES*XLEN-1:0] rf_rd;
  logic [LANES*XLEN-1:0]   opa_d, opb_d, imm_d;
  logic [LANES*RW-1:0]     rs_d, rt_d, rd_d;

  regfile_mp #(
    .LANES (LANES),
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite_w),
    .wa    (writereg_w),
    .wd    (result_w),
    .ra    (rf_ra),
    .rd    (rf_rd)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ILEN-1:0] iw;
    itype_t          ins;
    logic [XLEN-1:0] pc4, simm, zimm, opa, opb;
    logic [FW-1:0]   sel_a, sel_b;

    assign iw    = instr_d[lane_lo(i, ILEN) +: ILEN];
    assign ins   = itype_t'(iw);
    assign pc4   = pcplus4_d[lane_lo(i, XLEN) +: XLEN];
    assign sel_a = fwd_a_d[lane_lo(i, FW) +: FW];
    assign sel_b = fwd_b_d[lane_lo(i, FW) +: FW];

    assign rf_ra[rport_lo(LANES, i, 1'b0) +: RW] = ins.rs;
    assign rf_ra[rport_lo(LANES, i, 1'b1) +: RW] = ins.rt;

    assign simm = {{(XLEN-16){ins.imm[15]}}, ins.imm};
    assign zimm = {{(XLEN-16){1'b0}}, ins.imm};

    // selects past LANES have no MEM source and fall back to the regfile value
    always_comb begin
      opa = rf_rd[lane_lo(i, XLEN) +: XLEN];
      opb = rf_rd[lane_lo(LANES + i, XLEN) +: XLEN];
      for (int k = 0; k < LANES; k++) begin
        if (int'(sel_a) == k + 1) opa = aluout_m[lane_lo(k, XLEN) +: XLEN];
        if (int'(sel_b) == k + 1) opb = aluout_m[lane_lo(k, XLEN) +: XLEN];
      end
    end

    assign equal_d[i] = (opa == opb);
    assign pcbranch_d[lane_lo(i, XLEN) +: XLEN] = pc4 - XLEN'(4) + (simm << 2);
    assign jtarget_d[lane_lo(i, XLEN) +: XLEN]  = {pc4[XLEN-1:28], iw[25:0], 2'b00};

    assign opa_d[lane_lo(i, XLEN) +: XLEN] = opa;
    assign opb_d[lane_lo(i, XLEN) +: XLEN] = opb;
    assign imm_d[lane_lo(i, XLEN) +: XLEN] = is_zext_op(ins.op) ? zimm : simm;
    assign rs_d[lane_lo(i, RW) +: RW]      = ins.rs;
    assign rt_d[lane_lo(i, RW) +: RW]      = ins.rt;
    assign rd_d[lane_lo(i, RW) +: RW]      = ins.imm[15:11];
  end

  // invalid lanes are loaded like any other; valid_e alone marks them
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_e <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      imm_e   <= '0;
      rs_e    <= '0;
      rt_e    <= '0;
      rd_e    <= '0;
    end else if (!stall_d) begin
      valid_e <= valid_d;
      rd1_e   <= opa_d;
      rd2_e   <= opb_d;
      imm_e   <= imm_d;
      rs_e    <= rs_d;
      rt_e    <= rt_d;
      rd_e    <= rd_d;
    end
  end

endmodule
